// File: rtl/mem_pkg.sv
// Shared MEM-stage definitions: access size encoding, responder FSM states and
// the alignment rule used by both the core's request logic and the responder.
package mem_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10,
        MEM_RSVD = 2'b11
    } mem_size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_RESP = 2'b10
    } mem_state_e;

    localparam int MEM_LANES = 4;
    localparam int MEM_CNT_W = 4;

    // Reserved size is folded in here so one flag covers every encoding problem.
    function automatic logic mem_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (mem_size_e'(size))
            MEM_BYTE: return 1'b0;
            MEM_HALF: return addr_lo[0];
            MEM_WORD: return |addr_lo;
            default:  return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for one 32-bit word: store merge with lane enables,
// load lane select with sign/zero extension, and the misalignment flag.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    output logic [31:0] store_word,
    output logic [3:0]  lane_we,
    output logic [31:0] load_data,
    output logic        misalign
);

    logic [31:0] wdata_rep;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        wdata_rep = wdata;
        lane_we   = 4'b0000;
        load_data = old_word;
        ld_byte   = old_word[{addr_lo, 3'b000} +: 8];
        ld_half   = addr_lo[1] ? old_word[31:16] : old_word[15:0];
        case (mem_size_e'(size))
            MEM_BYTE: begin
                wdata_rep = {4{wdata[7:0]}};
                lane_we   = 4'b0001 << addr_lo;
                load_data = {{24{~is_unsigned & ld_byte[7]}}, ld_byte};
            end
            MEM_HALF: begin
                wdata_rep = {2{wdata[15:0]}};
                lane_we   = addr_lo[1] ? 4'b1100 : 4'b0011;
                load_data = {{16{~is_unsigned & ld_half[15]}}, ld_half};
            end
            MEM_WORD: lane_we = 4'b1111;
            default: begin
                lane_we   = 4'b0000;
                load_data = '0;
            end
        endcase
        store_word = old_word;
        for (int i = 0; i < MEM_LANES; i++) begin
            if (lane_we[i]) store_word[8*i +: 8] = wdata_rep[8*i +: 8];
        end
    end

    assign misalign = mem_misaligned(size, addr_lo);

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency slave for the core's data port: one request in flight, serviced
// against a byte-enabled word array, response held until the requester takes it.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    mem_state_e            state;
    logic [MEM_CNT_W-1:0]  cnt;
    logic                  cap_write;
    logic [31:0]           cap_addr;
    logic [31:0]           cap_wdata;
    logic [1:0]            cap_size;
    logic                  cap_unsigned;

    logic [31:0]           mem [DEPTH_WORDS];

    logic [AW-1:0]         word_idx;
    logic                  in_range;
    logic                  misalign;
    logic                  acc_err;
    logic                  do_access;
    logic [31:0]           old_word;
    logic [31:0]           store_word;
    logic [31:0]           load_data;
    logic [3:0]            lane_we;

    assign in_range  = cap_addr[31:2] < 30'(DEPTH_WORDS);
    assign word_idx  = cap_addr[AW+1:2];
    assign old_word  = in_range ? mem[word_idx] : '0;
    assign acc_err   = misalign | ~in_range;
    assign do_access = (state == ST_BUSY) && (cnt == '0);
    assign req_ready = (state == ST_IDLE) && !rst;

    mem_lane_align u_align (
        .addr_lo     (cap_addr[1:0]),
        .size        (cap_size),
        .is_unsigned (cap_unsigned),
        .old_word    (old_word),
        .wdata       (cap_wdata),
        .store_word  (store_word),
        .lane_we     (lane_we),
        .load_data   (load_data),
        .misalign    (misalign)
    );

    // Array is deliberately left out of reset; a store racing reset is dropped.
    always_ff @(posedge clk) begin
        if (!rst && do_access && cap_write && !acc_err) begin
            for (int i = 0; i < MEM_LANES; i++) begin
                if (lane_we[i]) mem[word_idx][8*i +: 8] <= store_word[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
            rsp_error    <= 1'b0;
            cap_write    <= 1'b0;
            cap_addr     <= '0;
            cap_wdata    <= '0;
            cap_size     <= '0;
            cap_unsigned <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        cap_write    <= req_write;
                        cap_addr     <= req_addr;
                        cap_wdata    <= req_wdata;
                        cap_size     <= req_size;
                        cap_unsigned <= req_unsigned;
                        cnt          <= MEM_CNT_W'(LATENCY - 1);
                        state        <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (cnt == '0) begin
                        rsp_valid <= 1'b1;
                        rsp_error <= acc_err;
                        rsp_rdata <= (acc_err || cap_write) ? 32'h0 : load_data;
                        state     <= ST_RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: a LATENCY=4 instance exercised across
// loads, stores, errors, backpressure and reset, plus a LATENCY=1 instance.
module tb_data_mem_responder;
    import mem_pkg::*;

    localparam int DEPTH_A = 64;
    localparam int LAT_A   = 4;
    localparam int DEPTH_B = 16;
    localparam int LAT_B   = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid, req_ready, req_write, req_unsigned;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        rsp_valid, rsp_ready, rsp_error;
    logic [31:0] rsp_rdata;

    logic        b_req_valid, b_req_ready, b_req_write, b_req_unsigned;
    logic [31:0] b_req_addr, b_req_wdata;
    logic [1:0]  b_req_size;
    logic        b_rsp_valid, b_rsp_ready, b_rsp_error;
    logic [31:0] b_rsp_rdata;

    data_mem_responder #(.DEPTH_WORDS(DEPTH_A), .LATENCY(LAT_A)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error)
    );

    data_mem_responder #(.DEPTH_WORDS(DEPTH_B), .LATENCY(LAT_B)) u_dut_b (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_size(b_req_size),
        .req_unsigned(b_req_unsigned),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
        .rsp_error(b_rsp_error)
    );

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    typedef struct packed {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [1:0]  sz;
        logic        u;
        logic [31:0] ed;
        logic        ee;
    } op_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acc_edge = 0;
    logic prev_v = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Response monitor for the LATENCY=4 instance: latency and data scoreboard.
    always @(negedge clk) begin
        if (req_valid && req_ready) acc_edge = cyc + 1;
        if (rsp_valid === 1'b1 && prev_v !== 1'b1) begin
            checks++;
            if (cyc - acc_edge != LAT_A) begin
                errors++;
                $display("FAIL latency_a: got %0d edges, expected %0d", cyc - acc_edge, LAT_A);
            end
        end
        if (rsp_valid === 1'b1 && rsp_ready && !rst) begin
            checks++;
            if (q_a.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rsp_a: rdata=%h err=%b with empty scoreboard", rsp_rdata, rsp_error);
            end else begin
                mon_e = q_a.pop_front();
                if (rsp_rdata !== mon_e.rdata || rsp_error !== mon_e.err) begin
                    errors++;
                    $display("FAIL rsp_a: got rdata=%h err=%b, expected rdata=%h err=%b",
                             rsp_rdata, rsp_error, mon_e.rdata, mon_e.err);
                end
            end
        end
        prev_v = rsp_valid;
    end

    task automatic send_a(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [1:0] sz, input logic u,
                          input logic [31:0] exp_d, input logic exp_e,
                          input bit push, input bit wait_done);
        int   n;
        exp_t e;
        n = 0;
        while (req_ready !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout_a addr=%h: req_ready=%b, expected 1", a, req_ready);
        end
        if (push) begin
            e.rdata = exp_d;
            e.err   = exp_e;
            q_a.push_back(e);
        end
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        req_size = sz; req_unsigned = u;
        @(posedge clk); #1;
        req_valid    = 1'b0;
        req_write    = 1'($urandom);
        req_addr     = $urandom;
        req_wdata    = $urandom;
        req_size     = 2'($urandom);
        req_unsigned = 1'($urandom);
        if (wait_done) begin
            n = 0;
            while (req_ready !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
            checks++;
            if (req_ready !== 1'b1) begin
                errors++;
                $display("FAIL done_timeout_a addr=%h: req_ready=%b, expected 1", a, req_ready);
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({req_ready, rsp_valid, rsp_error, rsp_rdata} !== 35'h0) begin
                errors++;
                $display("FAIL reset_init: rdy=%b vld=%b err=%b rdata=%h, expected all 0",
                         req_ready, rsp_valid, rsp_error, rsp_rdata);
            end
        end
        rst = 1'b0; #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL ready_after_reset: got %b, expected 1", req_ready);
        end
        repeat (2) @(posedge clk);
        #1; rst = 1'b1; #1;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++; $display("FAIL ready_during_rst: got %b, expected 0", req_ready);
        end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({req_ready, rsp_valid, rsp_error, rsp_rdata} !== 35'h0) begin
                errors++;
                $display("FAIL reset_idle: rdy=%b vld=%b err=%b rdata=%h, expected all 0",
                         req_ready, rsp_valid, rsp_error, rsp_rdata);
            end
        end
        rst = 1'b0; #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL ready_after_idle_reset: got %b, expected 1", req_ready);
        end
    endtask

    task automatic test_store_load();
        send_a(1'b1, 32'h00, 32'hA5A5A5A5, MEM_WORD, 1'b0, 32'h0, 1'b0, 1, 1);
        send_a(1'b1, 32'h10, 32'hDEADBEEF, MEM_WORD, 1'b0, 32'h0, 1'b0, 1, 1);
        send_a(1'b0, 32'h10, 32'h0,        MEM_WORD, 1'b0, 32'hDEADBEEF, 1'b0, 1, 1);
    endtask

    task automatic test_extend();
        send_a(1'b0, 32'h13, 32'h0, MEM_BYTE, 1'b0, 32'hFFFFFFDE, 1'b0, 1, 1);
        send_a(1'b0, 32'h13, 32'h0, MEM_BYTE, 1'b1, 32'h000000DE, 1'b0, 1, 1);
        send_a(1'b0, 32'h12, 32'h0, MEM_HALF, 1'b0, 32'hFFFFDEAD, 1'b0, 1, 1);
        send_a(1'b0, 32'h10, 32'h0, MEM_HALF, 1'b1, 32'h0000BEEF, 1'b0, 1, 1);
        send_a(1'b0, 32'h10, 32'h0, MEM_HALF, 1'b0, 32'hFFFFBEEF, 1'b0, 1, 1);
    endtask

    task automatic test_partial_store();
        send_a(1'b1, 32'h11, 32'hAAAAAA55, MEM_BYTE, 1'b0, 32'h0, 1'b0, 1, 1);
        send_a(1'b0, 32'h10, 32'h0,        MEM_WORD, 1'b0, 32'hDEAD55EF, 1'b0, 1, 1);
        send_a(1'b1, 32'h12, 32'hFFFF1234, MEM_HALF, 1'b0, 32'h0, 1'b0, 1, 1);
        send_a(1'b0, 32'h10, 32'h0,        MEM_WORD, 1'b0, 32'h123455EF, 1'b0, 1, 1);
        send_a(1'b0, 32'h11, 32'h0,        MEM_BYTE, 1'b0, 32'h00000055, 1'b0, 1, 1);
        send_a(1'b0, 32'h12, 32'h0,        MEM_HALF, 1'b0, 32'h00001234, 1'b0, 1, 1);
    endtask

    task automatic test_errors();
        send_a(1'b0, 32'h12,        32'h0,        MEM_WORD, 1'b0, 32'h0, 1'b1, 1, 1);
        send_a(1'b1, 32'h15,        32'h0000FFFF, MEM_HALF, 1'b0, 32'h0, 1'b1, 1, 1);
        send_a(1'b0, 32'h10,        32'h0,        MEM_RSVD, 1'b0, 32'h0, 1'b1, 1, 1);
        send_a(1'b0, 4 * DEPTH_A,   32'h0,        MEM_WORD, 1'b0, 32'h0, 1'b1, 1, 1);
        send_a(1'b1, 4 * DEPTH_A,   32'h11111111, MEM_WORD, 1'b0, 32'h0, 1'b1, 1, 1);
        send_a(1'b0, 32'h10,        32'h0,        MEM_WORD, 1'b0, 32'h123455EF, 1'b0, 1, 1);
        send_a(1'b0, 32'h00,        32'h0,        MEM_WORD, 1'b0, 32'hA5A5A5A5, 1'b0, 1, 1);
    endtask

    task automatic test_stall();
        int n;
        rsp_ready = 1'b0;
        send_a(1'b0, 32'h10, 32'h0, MEM_WORD, 1'b0, 32'h123455EF, 1'b0, 1, 0);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h123455EF || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold: vld=%b rdata=%h rdy=%b, expected vld=1 rdata=123455ef rdy=0",
                         rsp_valid, rsp_rdata, req_ready);
            end
        end
        rsp_ready = 1'b1;
        n = 0;
        while (req_ready !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL stall_release: req_ready=%b, expected 1", req_ready);
        end
    endtask

    task automatic test_reset_busy();
        send_a(1'b1, 32'h10, 32'hFFFFFFFF, MEM_WORD, 1'b0, 32'h0, 1'b0, 0, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: vld=%b rdy=%b, expected 0 0", rsp_valid, req_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0; #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL reset_busy_ready: got %b, expected 1", req_ready);
        end
        send_a(1'b0, 32'h10, 32'h0, MEM_WORD, 1'b0, 32'h123455EF, 1'b0, 1, 1);
    endtask

    task automatic test_latency1();
        op_t  ops[5];
        exp_t e;
        int   n;
        ops[0] = '{1'b1, 32'h08, 32'hCAFEF00D, MEM_WORD, 1'b0, 32'h0,        1'b0};
        ops[1] = '{1'b0, 32'h08, 32'h0,        MEM_WORD, 1'b0, 32'hCAFEF00D, 1'b0};
        ops[2] = '{1'b0, 32'h0A, 32'h0,        MEM_HALF, 1'b1, 32'h0000CAFE, 1'b0};
        ops[3] = '{1'b0, 32'h0B, 32'h0,        MEM_BYTE, 1'b0, 32'hFFFFFFCA, 1'b0};
        ops[4] = '{1'b0, 32'h40, 32'h0,        MEM_WORD, 1'b0, 32'h0,        1'b1};
        for (int i = 0; i < 5; i++) begin
            n = 0;
            while (b_req_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
            e.rdata = ops[i].ed;
            e.err   = ops[i].ee;
            q_b.push_back(e);
            b_req_valid = 1'b1; b_req_write = ops[i].w; b_req_addr = ops[i].a;
            b_req_wdata = ops[i].d; b_req_size = ops[i].sz; b_req_unsigned = ops[i].u;
            @(posedge clk); #1;
            b_req_valid = 1'b0;
            b_req_addr  = $urandom;
            b_req_wdata = $urandom;
            n = 0;
            while (b_rsp_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
            checks++;
            if (n != LAT_B) begin
                errors++; $display("FAIL latency_b op%0d: got %0d edges, expected %0d", i, n, LAT_B);
            end
            e = q_b.pop_front();
            checks++;
            if (b_rsp_rdata !== e.rdata || b_rsp_error !== e.err) begin
                errors++;
                $display("FAIL rsp_b op%0d: got rdata=%h err=%b, expected rdata=%h err=%b",
                         i, b_rsp_rdata, b_rsp_error, e.rdata, e.err);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        req_size = 2'b00; req_unsigned = 1'b0; rsp_ready = 1'b1;
        b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = '0; b_req_wdata = '0;
        b_req_size = 2'b00; b_req_unsigned = 1'b0; b_rsp_ready = 1'b1;

        test_reset();
        test_store_load();
        test_extend();
        test_partial_store();
        test_errors();
        test_stall();
        test_reset_busy();
        test_latency1();

        repeat (2) @(posedge clk);
        checks++;
        if (q_a.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: %0d responses outstanding, expected 0", q_a.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
